// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared mode and FSM state types for the serial word loader
package loader_pkg;

   // Operation selected by the mode switches, acted on once per press
   typedef enum logic [1:0] {
      MODE_IDLE  = 2'b00,
      MODE_KEY   = 2'b01,
      MODE_TEXT  = 2'b10,
      MODE_CLEAR = 2'b11
   } mode_e;

   // Press-handling FSM: one SHIFT cycle per debounced press
   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      SHIFT        = 2'b01,
      WAIT_RELEASE = 2'b10
   } state_e;

endpackage

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - input synchronizers and optional ready debounce (SERIAL_WORD_LOADER_DEBOUNCE_EN)
module sync_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic ready,
   input  logic in_bit,
   output logic ready_db,
   output logic bit_s
);

   logic [1:0] ready_sync;
   logic [1:0] bit_sync;
   logic       ready_s;

   // Two-flop synchronizers for both asynchronous switch inputs
   always_ff @(posedge clock) begin
      if (reset) begin
         ready_sync <= 2'b00;
         bit_sync   <= 2'b00;
      end else begin
         ready_sync <= {ready_sync[0], ready};
         bit_sync   <= {bit_sync[0], in_bit};
      end
   end

   assign ready_s = ready_sync[1];
   assign bit_s   = bit_sync[1];

   // A debounce length below one cycle has no meaning; nothing is built for it
   if (DEBOUNCE_CYCLES < 1) begin : g_invalid_debounce
   end

`ifdef SERIAL_WORD_LOADER_DEBOUNCE_EN

   localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [DEB_W-1:0] deb_count;
   logic             ready_q;

   // ready_q only follows ready_s after it has differed for DEBOUNCE_CYCLES cycles in a row
   always_ff @(posedge clock) begin
      if (reset) begin
         deb_count <= '0;
         ready_q   <= 1'b0;
      end else if (ready_s != ready_q) begin
         if (deb_count == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            ready_q   <= ready_s;
            deb_count <= '0;
         end else begin
            deb_count <= deb_count + 1'b1;
         end
      end else begin
         deb_count <= '0;
      end
   end

   assign ready_db = ready_q;

`else

   // Clean stimulus source: the synchronized button is used as-is
   assign ready_db = ready_s;

`endif

endmodule

// File: rtl/serial_word_loader.sv
// rtl/serial_word_loader.sv - press-driven serial loader for key and text words (SERIAL_WORD_LOADER_DEBOUNCE_EN)
module serial_word_loader
   import loader_pkg::*;
#(
   parameter  int WIDTH           = 16,
   parameter  int DEBOUNCE_CYCLES = 4,
   localparam int CW              = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_bit,
   input  logic             ready,
   input  logic [1:0]       mode_sel,
   output logic [WIDTH-1:0] key,
   output logic [WIDTH-1:0] intxt,
   output logic [CW-1:0]    key_count,
   output logic [CW-1:0]    text_count,
   output logic             key_valid,
   output logic             intxt_valid,
   output logic             load_pulse
);

   localparam logic [CW-1:0] FULL = CW'(WIDTH);

   logic   ready_db;
   logic   bit_s;
   state_e state;

   sync_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_sync_debounce (
      .clock   (clock),
      .reset   (reset),
      .ready   (ready),
      .in_bit  (in_bit),
      .ready_db(ready_db),
      .bit_s   (bit_s)
   );

   // One action per debounced press; mode and data are sampled only in SHIFT
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         key        <= '0;
         intxt      <= '0;
         key_count  <= '0;
         text_count <= '0;
         load_pulse <= 1'b0;
      end else begin
         load_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (ready_db) begin
                  state      <= SHIFT;
                  load_pulse <= 1'b1;
               end
            end
            SHIFT: begin
               state <= WAIT_RELEASE;
               case (mode_e'(mode_sel))
                  MODE_KEY: begin
                     key <= {key[WIDTH-2:0], bit_s};
                     if (key_count != FULL) key_count <= key_count + 1'b1;
                  end
                  MODE_TEXT: begin
                     intxt <= {intxt[WIDTH-2:0], bit_s};
                     if (text_count != FULL) text_count <= text_count + 1'b1;
                  end
                  MODE_CLEAR: begin
                     key        <= '0;
                     intxt      <= '0;
                     key_count  <= '0;
                     text_count <= '0;
                  end
                  default: begin
                  end
               endcase
            end
            WAIT_RELEASE: begin
               if (!ready_db) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign key_valid   = (key_count == FULL);
   assign intxt_valid = (text_count == FULL);

endmodule

// File: tb/tb_serial_word_loader.sv
// tb/tb_serial_word_loader.sv - self-checking bench for serial_word_loader
module tb_serial_word_loader;

   localparam int W  = 16;
   localparam int CW = $clog2(W + 1);
`ifdef SERIAL_WORD_LOADER_DEBOUNCE_EN
   localparam int DEB = 4;
   localparam int BOUNCE_PRESSES = 1;
`else
   localparam int DEB = 0;
   localparam int BOUNCE_PRESSES = 2;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          in_bit;
   logic          ready;
   logic [1:0]    mode_sel;
   logic [W-1:0]  key;
   logic [W-1:0]  intxt;
   logic [CW-1:0] key_count;
   logic [CW-1:0] text_count;
   logic          key_valid;
   logic          intxt_valid;
   logic          load_pulse;

   int total = 0;
   int bad   = 0;

   serial_word_loader #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_bit     (in_bit),
      .ready      (ready),
      .mode_sel   (mode_sel),
      .key        (key),
      .intxt      (intxt),
      .key_count  (key_count),
      .text_count (text_count),
      .key_valid  (key_valid),
      .intxt_valid(intxt_valid),
      .load_pulse (load_pulse)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] mode;
      logic       bit_v;
      int         exp_key;
      int         exp_txt;
      int         exp_kc;
      int         exp_tc;
   } vec_t;

   vec_t vecs[$];

   // Reference model of the loaded words
   int key_m, txt_m, kc_m, tc_m;

   function automatic void model_apply(input logic [1:0] m, input logic b);
      case (m)
         2'b01: begin
            key_m = ((key_m * 2) + int'(b)) % 65536;
            kc_m  = (kc_m < W) ? kc_m + 1 : W;
         end
         2'b10: begin
            txt_m = ((txt_m * 2) + int'(b)) % 65536;
            tc_m  = (tc_m < W) ? tc_m + 1 : W;
         end
         2'b11: begin
            key_m = 0; txt_m = 0; kc_m = 0; tc_m = 0;
         end
         default: ;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   task automatic check_state(input string tag, input int ek, input int et, input int ekc, input int etc_v);
      check({tag, " key"}, 32'(key), 32'(ek));
      check({tag, " intxt"}, 32'(intxt), 32'(et));
      check({tag, " key_count"}, 32'(key_count), 32'(ekc));
      check({tag, " text_count"}, 32'(text_count), 32'(etc_v));
      check({tag, " key_valid"}, 32'(key_valid), 32'(ekc == W));
      check({tag, " intxt_valid"}, 32'(intxt_valid), 32'(etc_v == W));
   endtask

   // Clean press: data stable, button held well past latency, then released
   task automatic press(input logic [1:0] m, input logic b, output int pulses);
      pulses = 0;
      @(negedge clock);
      mode_sel = m; in_bit = b; ready = 1'b1;
      repeat (14) begin
         @(negedge clock);
         if (load_pulse) pulses++;
      end
      ready = 1'b0;
      repeat (14) begin
         @(negedge clock);
         if (load_pulse) pulses++;
      end
   endtask

   initial begin
      int         pulses;
      int         first;
      logic [15:0] pat;
      logic [1:0]  rm;
      logic        rb;

      reset = 1'b1; ready = 1'b0; in_bit = 1'b0; mode_sel = 2'b00;
      repeat (3) @(negedge clock);
      check_state("reset", 0, 0, 0, 0);
      check("reset load_pulse", 32'(load_pulse), 32'd0);
      reset = 1'b0;

      // Press table: key 0xA5C3, text 0x1234 plus one extra bit, idle, clear, alternating modes
      pat = 16'hA5C3;
      for (int i = 0; i < 16; i++)
         vecs.push_back('{2'b01, pat[15-i], int'(pat) >> (15 - i), 0, i + 1, 0});
      pat = 16'h1234;
      for (int i = 0; i < 16; i++)
         vecs.push_back('{2'b10, pat[15-i], 32'hA5C3, int'(pat) >> (15 - i), 16, i + 1});
      vecs.push_back('{2'b10, 1'b1, 32'hA5C3, 32'h2469, 16, 16});
      vecs.push_back('{2'b00, 1'b1, 32'hA5C3, 32'h2469, 16, 16});
      vecs.push_back('{2'b11, 1'b1, 0, 0, 0, 0});
      vecs.push_back('{2'b01, 1'b1, 1, 0, 1, 0});
      vecs.push_back('{2'b01, 1'b0, 2, 0, 2, 0});
      vecs.push_back('{2'b01, 1'b1, 5, 0, 3, 0});
      vecs.push_back('{2'b10, 1'b1, 5, 1, 3, 1});
      vecs.push_back('{2'b10, 1'b1, 5, 3, 3, 2});
      vecs.push_back('{2'b10, 1'b0, 5, 6, 3, 3});
      vecs.push_back('{2'b10, 1'b0, 5, 12, 3, 4});
      vecs.push_back('{2'b10, 1'b1, 5, 25, 3, 5});
      vecs.push_back('{2'b01, 1'b1, 11, 25, 4, 5});
      vecs.push_back('{2'b01, 1'b1, 23, 25, 5, 5});

      foreach (vecs[i]) begin
         press(vecs[i].mode, vecs[i].bit_v, pulses);
         check($sformatf("row%0d pulses", i), 32'(pulses), 32'd1);
         check_state($sformatf("row%0d", i), vecs[i].exp_key, vecs[i].exp_txt,
                     vecs[i].exp_kc, vecs[i].exp_tc);
      end

      key_m = 23; txt_m = 25; kc_m = 5; tc_m = 5;

      // Bouncing button followed by a long hold
      pulses = 0;
      @(negedge clock);
      mode_sel = 2'b01; in_bit = 1'b1;
      ready = 1'b1;
      repeat (2) begin @(negedge clock); if (load_pulse) pulses++; end
      ready = 1'b0;
      repeat (2) begin @(negedge clock); if (load_pulse) pulses++; end
      ready = 1'b1;
      repeat (72) begin @(negedge clock); if (load_pulse) pulses++; end
      ready = 1'b0;
      repeat (14) begin @(negedge clock); if (load_pulse) pulses++; end
      check("bounce pulses", 32'(pulses), 32'(BOUNCE_PRESSES));
      for (int n = 0; n < BOUNCE_PRESSES; n++) model_apply(2'b01, 1'b1);
      check_state("bounce", key_m, txt_m, kc_m, tc_m);

      // Random presses against the model
      for (int i = 0; i < 40; i++) begin
         rm = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
         rb = 1'($urandom);
         press(rm, rb, pulses);
         model_apply(rm, rb);
         check($sformatf("rand%0d pulses", i), 32'(pulses), 32'd1);
         check_state($sformatf("rand%0d", i), key_m, txt_m, kc_m, tc_m);
      end

      // Reset while held in WAIT_RELEASE, then the held button counts as a new press
      press(2'b01, 1'b1, pulses);
      @(negedge clock);
      mode_sel = 2'b01; in_bit = 1'b1; ready = 1'b1;
      first = 0;
      for (int k = 1; k <= 20 && first == 0; k++) begin
         @(negedge clock);
         if (load_pulse) first = k;
      end
      check("pre-reset press seen", 32'(first != 0), 32'd1);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_state("held reset", 0, 0, 0, 0);
      check("held reset load_pulse", 32'(load_pulse), 32'd0);
      reset = 1'b0;
      first = 0;
      for (int k = 1; k <= 20 && first == 0; k++) begin
         @(negedge clock);
         if (load_pulse) first = k;
      end
      check("post-reset pulse edge", 32'(first), 32'(3 + DEB));
      check("post-reset key before update", 32'(key), 32'd0);
      @(negedge clock);
      check_state("post-reset shift", 1, 0, 1, 0);
      pulses = 0;
      repeat (20) begin @(negedge clock); if (load_pulse) pulses++; end
      check("post-reset hold no extra", 32'(pulses), 32'd0);
      ready = 1'b0;
      repeat (10) @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
